// File: rtl/uart_rx_core_if.sv
// Serial receive bus: line input and divider from the system side,
// received byte and status pulses toward the UART register block.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
);
    logic [DIV_W-1:0]     clk_div;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output clk_div, rx,
        input  rx_data, rx_done, frame_err, busy
    );

    modport slave (
        input  clk_div, rx,
        output rx_data, rx_done, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx, oversamples it with an internal tick and
// deframes 8N1 characters into rx_data with single-cycle rx_done/frame_err.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised line
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling data bits at bit centres, LSB first
// STOP  | sampling the stop bit at its centre
// BRK   | stop bit was low; wait for the line to return high
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_core_if.slave  bus
);
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS + 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     tcnt_q, tcnt_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_s;
    logic                 tick;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (tcnt_q == div_q);

    // Synchroniser chain; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
        end
    end

    // State, counters, shift register and registered output pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            tcnt_q      <= '0;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tcnt_q      <= tcnt_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: tick generation, sample/bit counting and deframing
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tcnt_d      = tcnt_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE) begin
            tcnt_d = tick ? '0 : tcnt_q + 1'b1;
            if (tick) begin
                scnt_d = scnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    scnt_d  = '0;
                    bcnt_d  = '0;
                    div_d   = bus.clk_div;
                end
            end
            START: begin
                if (tick && scnt_q == SCNT_MID) begin
                    scnt_d = '0;
                    // A line already back high at mid start bit is a glitch
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && scnt_q == SCNT_LAST) begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    scnt_d  = '0;
                    if (bcnt_q == BCNT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a directly following start bit be caught
                if (tick && scnt_q == SCNT_LAST) begin
                    scnt_d = '0;
                    if (rx_s) begin
                        rx_data_d = shreg_q;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            tcnt_d = '0;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: table of good frames at several dividers plus
// hand-built sequences for glitch, framing error, back-to-back, divider
// change mid-frame and reset mid-frame. Expected bytes and completion
// cycles go into scoreboard queues when a frame is driven.
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_core_if #(.DATA_BITS(8), .DIV_W(16)) bus ();

    uart_rx_core #(
        .DATA_BITS(8), .DIV_W(16), .OVERSAMPLE(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        int          lat;
    } vec_t;

    exp_t       exp_q[$];
    int         fe_q[$];
    int         done_log[$];
    logic [7:0] model_last = 8'h00;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is always aligned 1 time unit after a rising edge
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk,
                              input int lat, input bit expect_it);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = bits[i];
            if (i == 0 && expect_it) begin
                if (stop) exp_q.push_back('{d, cyc + lat});
                else      fe_q.push_back(cyc + lat);
            end
            wait_clks(bclk);
        end
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n;
        n = 0;
        while (bus.busy && n < maxc) begin
            wait_clks(1);
            n++;
        end
        check(!bus.busy, name, bus.busy, 0);
    endtask

    // Scoreboard: consume expected bytes / framing errors as the DUT pulses
    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (!reset_n) begin
            model_last = 8'h00;
        end else begin
            if (bus.rx_done && bus.frame_err)
                check(0, "done_and_ferr_together", 1, 0);
            if (bus.rx_done) begin
                done_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_rx_done", bus.rx_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.rx_data == e.data, "rx_data", bus.rx_data, e.data);
                    check(cyc == e.exp_cyc, "rx_done_cycle", cyc, e.exp_cyc);
                    model_last = e.data;
                end
            end
            if (bus.frame_err) begin
                if (fe_q.size() == 0) begin
                    check(0, "unexpected_frame_err", 1, 0);
                end else begin
                    c = fe_q.pop_front();
                    check(cyc == c, "frame_err_cycle", cyc, c);
                    check(bus.rx_data == model_last, "rx_data_hold_on_ferr", bus.rx_data, model_last);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   n0;
        vecs[0] = '{8'hA5, 16'd3, 611};
        vecs[1] = '{8'h3C, 16'd3, 611};
        vecs[2] = '{8'h00, 16'd1, 307};
        vecs[3] = '{8'hFF, 16'd2, 459};
        vecs[4] = '{8'h5A, 16'd0, 155};
        vecs[5] = '{8'hC3, 16'd3, 611};

        bus.rx = 1'b1;
        bus.clk_div = 16'd3;
        reset_n = 1'b0;
        wait_clks(3);
        check(bus.rx_data == 8'h00, "reset_rx_data", bus.rx_data, 0);
        check(bus.rx_done == 1'b0, "reset_rx_done", bus.rx_done, 0);
        check(bus.frame_err == 1'b0, "reset_frame_err", bus.frame_err, 0);
        check(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
        reset_n = 1'b1;
        wait_clks(5);

        // Good frames across dividers
        for (int i = 0; i < 6; i++) begin
            bus.clk_div = vecs[i].div;
            send_frame(vecs[i].data, 1'b1, 16 * (int'(vecs[i].div) + 1), vecs[i].lat, 1'b1);
            wait_clks(4);
            check(exp_q.size() == 0, "vec_rx_done_seen", exp_q.size(), 0);
            check(bus.rx_data == vecs[i].data, "vec_rx_data", bus.rx_data, vecs[i].data);
            check(!bus.busy, "vec_idle", bus.busy, 0);
        end

        // Short low glitch rejected at mid start bit
        bus.clk_div = 16'd3;
        n0 = done_log.size();
        bus.rx = 1'b0;
        wait_clks(10);
        check(bus.busy == 1'b1, "glitch_busy_high", bus.busy, 1);
        wait_clks(10);
        bus.rx = 1'b1;
        wait_clks(60);
        check(!bus.busy, "glitch_busy_low", bus.busy, 0);
        check(done_log.size() == n0, "glitch_no_rx_done", done_log.size(), n0);
        check(bus.rx_data == 8'hC3, "glitch_rx_data_kept", bus.rx_data, 8'hC3);

        // Stop bit low, then line held low (break)
        send_frame(8'h3C, 1'b0, 64, 611, 1'b1);
        wait_clks(200);
        check(bus.busy == 1'b1, "break_busy", bus.busy, 1);
        check(fe_q.size() == 0, "ferr_seen", fe_q.size(), 0);
        bus.rx = 1'b1;
        wait_idle(10, "break_exit_idle");
        check(bus.rx_data == 8'hC3, "rx_data_after_ferr", bus.rx_data, 8'hC3);
        wait_clks(20);

        // Back-to-back frames, no idle gap
        n0 = done_log.size();
        send_frame(8'h00, 1'b1, 64, 611, 1'b1);
        send_frame(8'hFF, 1'b1, 64, 611, 1'b1);
        wait_clks(4);
        check(done_log.size() == n0 + 2, "b2b_pulse_count", done_log.size(), n0 + 2);
        if (done_log.size() == n0 + 2)
            check(done_log[n0+1] - done_log[n0] == 640, "b2b_spacing",
                  done_log[n0+1] - done_log[n0], 640);
        check(bus.rx_data == 8'hFF, "b2b_last_data", bus.rx_data, 8'hFF);

        // Divider change mid-frame must not affect the frame in flight
        bus.clk_div = 16'd0;
        fork
            send_frame(8'h81, 1'b1, 16, 155, 1'b1);
            begin
                wait_clks(50);
                bus.clk_div = 16'd9;
            end
        join
        wait_clks(4);
        check(exp_q.size() == 0, "divchg_rx_done_seen", exp_q.size(), 0);
        check(bus.rx_data == 8'h81, "divchg_rx_data", bus.rx_data, 8'h81);
        bus.clk_div = 16'd3;
        wait_clks(10);

        // Reset during data bit 4; upper nibble high so the tail cannot start a frame
        fork
            send_frame(8'hF5, 1'b1, 64, 0, 1'b0);
            begin
                wait_clks(340);
                check(bus.busy == 1'b1, "pre_reset_busy", bus.busy, 1);
                reset_n = 1'b0;
                #2;
                check(bus.rx_data == 8'h00, "midreset_rx_data", bus.rx_data, 0);
                check(bus.rx_done == 1'b0, "midreset_rx_done", bus.rx_done, 0);
                check(bus.frame_err == 1'b0, "midreset_frame_err", bus.frame_err, 0);
                check(bus.busy == 1'b0, "midreset_busy", bus.busy, 0);
                wait_clks(5);
                reset_n = 1'b1;
            end
        join
        wait_clks(10);
        check(!bus.busy, "post_reset_idle", bus.busy, 0);
        send_frame(8'h5A, 1'b1, 64, 611, 1'b1);
        wait_clks(4);
        check(bus.rx_data == 8'h5A, "post_reset_rx_data", bus.rx_data, 8'h5A);

        check(exp_q.size() == 0, "pending_rx_done", exp_q.size(), 0);
        check(fe_q.size() == 0, "pending_frame_err", fe_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
